mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/dff.sv | 26 ++
 rtl/mem_stage_wait_cnt.sv | 49 ++++
 rtl/mem_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_stage.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline package for the memory stage.
// Holds the memory-stage FSM state encoding and the default number of
// cycles an access may sit in WAIT before it is declared timed out.
package mem_stage_pkg;

  // Memory-stage access FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Default WAIT cycles allowed before a timeout error.
  localparam int MEM_MAX_WAIT_DEFAULT = 15;

endpackage : mem_stage_pkg

// File: rtl/dff.sv
// Generic storage cell used for every state element in the pipeline.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset, clears q to zero
//   en  - load enable
//   d   - next value, loaded on a rising clk edge while en is high
//   q   - stored value
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : dff

// File: rtl/mem_stage_wait_cnt.sv
// Wait counter for the memory stage. Counts cycles spent in WAIT and flags
// the last cycle allowed before a timeout.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset
//   clr - force the count to zero (wins over en)
//   en  - advance the count by one
//   tc  - high while the count is on the final allowed WAIT cycle
module mem_wait_cnt
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = MEM_MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // The count never needs to exceed MAX_WAIT-1.
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // The first WAIT cycle sees a count of 0, so the MAX_WAIT-th WAIT cycle
  // sees MAX_WAIT-1.
  assign tc = (cnt_reg == CW'(MAX_WAIT - 1));

  // Hold at the terminal count so the register never wraps.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en && !tc) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  dff #(.W(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (cnt_next),
    .q   (cnt_reg)
  );

endmodule : mem_wait_cnt

// File: rtl/mem_stage.sv
// Memory pipeline stage. Issues single-cycle read/write strobes for the
// instruction in EX/MEM, freezes the front of the pipe while a slow access
// is outstanding, and flags unaligned accesses and timeouts in a sticky
// error bit. A HALT instruction permanently disables further accesses.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   MEM_valid .. MEM_halt   - instruction held in EX/MEM
//   mem_done, mem_rd_data   - memory completion and read data
//   mem_addr, mem_wr_data   - memory address / store data
//   mem_rd, mem_wr          - one-cycle request strobes
//   MEM_mem_data            - load result for MEM/WB (0 for non-loads)
//   stall_pipe, wb_bubble   - freeze upstream stages / kill MEM/WB write
//   MEM_err                 - sticky unaligned/timeout error
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = MEM_MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid,
  input  logic [15:0] MEM_EX_out,
  input  logic [15:0] MEM_wr_data,
  input  logic        MEM_mem_read,
  input  logic        MEM_mem_write,
  input  logic        MEM_halt,
  input  logic        mem_done,
  input  logic [15:0] mem_rd_data,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wr_data,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] MEM_mem_data,
  output logic        stall_pipe,
  output logic        wb_bubble,
  output logic        MEM_err
);

  logic [1:0]  state_raw;
  mem_state_e  state_reg;
  mem_state_e  state_next;
  logic        halted_reg;
  logic        err_reg;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic        is_wr_reg;
  logic [15:0] cap_reg;

  logic        access;
  logic        set_halt;
  logic        set_err;
  logic        req_fire;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_tc;
  logic        cap_en;
  logic        rd_c;
  logic        wr_c;
  logic        stall_c;
  logic [15:0] addr_c;
  logic [15:0] wdata_c;
  logic [15:0] data_c;

  assign state_reg = mem_state_e'(state_raw);
  assign access    = MEM_valid & (MEM_mem_read | MEM_mem_write) & ~halted_reg & ~err_reg;

  always_comb begin
    state_next = state_reg;
    set_halt   = 1'b0;
    set_err    = 1'b0;
    req_fire   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cap_en     = 1'b0;
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    stall_c    = 1'b0;
    addr_c     = MEM_EX_out;
    wdata_c    = MEM_wr_data;
    data_c     = 16'h0000;
    case (state_reg)
      IDLE: begin
        if (MEM_valid && MEM_halt) begin
          set_halt = 1'b1;
        end else if (access) begin
          if (MEM_EX_out[0]) begin
            set_err = 1'b1;
          end else begin
            // A combined read+write is treated as a plain store.
            req_fire = 1'b1;
            wr_c     = MEM_mem_write;
            rd_c     = ~MEM_mem_write;
            if (mem_done) begin
              data_c = MEM_mem_write ? 16'h0000 : mem_rd_data;
            end else begin
              stall_c    = 1'b1;
              cnt_clr    = 1'b1;
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        addr_c  = addr_reg;
        wdata_c = wdata_reg;
        stall_c = 1'b1;
        cnt_en  = 1'b1;
        if (mem_done) begin
          cap_en     = 1'b1;
          state_next = DONE;
        end else if (cnt_tc) begin
          set_err    = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: begin
        addr_c     = addr_reg;
        wdata_c    = wdata_reg;
        data_c     = cap_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  dff #(.W(2)) u_state (
    .clk (clk), .rst (rst), .en (1'b1), .d (state_next), .q (state_raw)
  );

  dff #(.W(1)) u_halted (
    .clk (clk), .rst (rst), .en (set_halt), .d (1'b1), .q (halted_reg)
  );

  dff #(.W(1)) u_err (
    .clk (clk), .rst (rst), .en (set_err), .d (1'b1), .q (err_reg)
  );

  // Address, store data and direction are held for the WAIT/DONE cycles.
  dff #(.W(33)) u_latch (
    .clk (clk),
    .rst (rst),
    .en  (req_fire),
    .d   ({MEM_mem_write, MEM_wr_data, MEM_EX_out}),
    .q   ({is_wr_reg, wdata_reg, addr_reg})
  );

  // Stores capture zero so MEM_mem_data stays 0 for non-loads in DONE.
  dff #(.W(16)) u_cap (
    .clk (clk),
    .rst (rst),
    .en  (cap_en),
    .d   (is_wr_reg ? 16'h0000 : mem_rd_data),
    .q   (cap_reg)
  );

  mem_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  // Outputs are gated by rst so they drop immediately on reset, including
  // the combinational IDLE pass-through of MEM_EX_out / MEM_wr_data.
  assign mem_addr     = rst ? 16'h0000 : addr_c;
  assign mem_wr_data  = rst ? 16'h0000 : wdata_c;
  assign mem_rd       = rd_c & ~rst;
  assign mem_wr       = wr_c & ~rst;
  assign MEM_mem_data = rst ? 16'h0000 : data_c;
  assign stall_pipe   = stall_c & ~rst;
  assign wb_bubble    = stall_pipe;
  assign MEM_err      = err_reg & ~rst;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal
// expectations plus randomized episodes checked every cycle against a
// transaction-level reference model.
module tb_mem_stage;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_valid;
  logic [15:0] MEM_EX_out;
  logic [15:0] MEM_wr_data;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic        MEM_halt;
  logic        mem_done;
  logic [15:0] mem_rd_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] MEM_mem_data;
  logic        stall_pipe;
  logic        wb_bubble;
  logic        MEM_err;

  int checks = 0;
  int errors = 0;
  int ntx    = 0;

  mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_valid    (MEM_valid),
    .MEM_EX_out   (MEM_EX_out),
    .MEM_wr_data  (MEM_wr_data),
    .MEM_mem_read (MEM_mem_read),
    .MEM_mem_write(MEM_mem_write),
    .MEM_halt     (MEM_halt),
    .mem_done     (mem_done),
    .mem_rd_data  (mem_rd_data),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .MEM_mem_data (MEM_mem_data),
    .stall_pipe   (stall_pipe),
    .wb_bubble    (wb_bubble),
    .MEM_err      (MEM_err)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the outstanding access as "pending with N waited cycles" and a
  // one-shot "show result" cycle after completion.
  bit          m_pend, m_show, m_halted, m_err, m_lwr;
  int          m_waited;
  logic [15:0] m_laddr, m_lwdata, m_sdata;
  logic [15:0] e_addr, e_wd, e_data;
  logic        e_rd, e_wr, e_stall, e_err;

  always begin
    @(negedge clk);
    e_addr = 16'h0; e_wd = 16'h0; e_data = 16'h0;
    e_rd = 1'b0; e_wr = 1'b0; e_stall = 1'b0; e_err = 1'b0;
    if (rst) begin
      m_pend = 0; m_show = 0; m_halted = 0; m_err = 0; m_lwr = 0;
      m_waited = 0; m_laddr = 16'h0; m_lwdata = 16'h0; m_sdata = 16'h0;
    end else begin
      e_err = m_err;
      if (m_pend || m_show) begin
        e_addr = m_laddr; e_wd = m_lwdata;
      end else begin
        e_addr = MEM_EX_out; e_wd = MEM_wr_data;
      end
      if (m_show) begin
        e_data = m_sdata;
        m_show = 0;
      end else if (m_pend) begin
        e_stall = 1'b1;
        m_waited++;
        if (mem_done) begin
          m_pend = 0; m_show = 1;
          m_sdata = m_lwr ? 16'h0 : mem_rd_data;
        end else if (m_waited >= MAX_WAIT) begin
          m_pend = 0; m_err = 1;
          $display("txn timeout addr=0x%h after %0d wait cycles", m_laddr, m_waited);
        end
      end else if (MEM_valid && MEM_halt) begin
        m_halted = 1;
      end else if (MEM_valid && (MEM_mem_read || MEM_mem_write) && !m_halted && !m_err) begin
        if (MEM_EX_out[0]) begin
          m_err = 1;
          $display("txn unaligned addr=0x%h", MEM_EX_out);
        end else begin
          e_wr = MEM_mem_write;
          e_rd = !MEM_mem_write;
          m_laddr = MEM_EX_out; m_lwdata = MEM_wr_data; m_lwr = MEM_mem_write;
          ntx++;
          $display("txn %0d: %s addr=0x%h wdata=0x%h %s", ntx, MEM_mem_write ? "WR" : "RD",
                   MEM_EX_out, MEM_wr_data, mem_done ? "hit" : "miss");
          if (mem_done) begin
            e_data = MEM_mem_write ? 16'h0 : mem_rd_data;
          end else begin
            e_stall = 1'b1; m_pend = 1; m_waited = 0;
          end
        end
      end
    end
    chk16("model_addr", mem_addr, e_addr);
    chk16("model_wdata", mem_wr_data, e_wd);
    chk16("model_data", MEM_mem_data, e_data);
    chk1("model_rd", mem_rd, e_rd);
    chk1("model_wr", mem_wr, e_wr);
    chk1("model_stall", stall_pipe, e_stall);
    chk1("model_bubble", wb_bubble, e_stall);
    chk1("model_err", MEM_err, e_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic r, input logic w, input logic h,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic d, input logic [15:0] rdd);
    @(posedge clk); #1;
    MEM_valid = v; MEM_mem_read = r; MEM_mem_write = w; MEM_halt = h;
    MEM_EX_out = a; MEM_wr_data = wd; mem_done = d; mem_rd_data = rdd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    MEM_valid = 0; MEM_mem_read = 0; MEM_mem_write = 0; MEM_halt = 0;
    MEM_EX_out = 0; MEM_wr_data = 0; mem_done = 0; mem_rd_data = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int stalls;
  int wrs;
  int pd[8]    = '{90, 60, 30, 10, 3, 0, 50, 20};
  int punal[8] = '{0, 5, 0, 10, 0, 0, 2, 0};
  int phalt[8] = '{0, 0, 5, 0, 0, 0, 10, 0};

  initial begin
    // Reset with busy-looking inputs: outputs must still read zero.
    rst = 1'b1;
    MEM_valid = 1; MEM_mem_read = 1; MEM_mem_write = 0; MEM_halt = 0;
    MEM_EX_out = 16'hFFFE; MEM_wr_data = 16'h5555; mem_done = 1; mem_rd_data = 16'hBEEF;
    @(negedge clk);
    chk16("rst_addr", mem_addr, 16'h0);
    chk16("rst_wdata", mem_wr_data, 16'h0);
    chk16("rst_data", MEM_mem_data, 16'h0);
    chk16("rst_flags", 16'({mem_rd, mem_wr, stall_pipe, wb_bubble, MEM_err}), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    MEM_valid = 0; MEM_mem_read = 0; mem_done = 0;
    @(negedge clk);

    // Hit load.
    drive(1, 1, 0, 0, 16'h0010, 16'h0, 1, 16'hBEEF);
    chk1("hit_rd", mem_rd, 1'b1);
    chk16("hit_data", MEM_mem_data, 16'hBEEF);
    chk1("hit_stall", stall_pipe, 1'b0);
    chk16("hit_addr", mem_addr, 16'h0010);
    idle();
    chk1("hit_after_rd", mem_rd, 1'b0);
    chk1("hit_after_stall", stall_pipe, 1'b0);

    // Miss load: completes in the second WAIT cycle.
    drive(1, 1, 0, 0, 16'h0010, 16'h0, 0, 16'h0);
    chk1("miss_rd", mem_rd, 1'b1);
    stalls = int'(stall_pipe);
    for (int k = 1; k <= 2; k++) begin
      drive(1, 1, 0, 0, 16'h0ABC, 16'h0, (k == 2), (k == 2) ? 16'h1234 : 16'hDEAD);
      chk16("miss_addr", mem_addr, 16'h0010);
      chk1("miss_no_restrobe", mem_rd, 1'b0);
      stalls += int'(stall_pipe);
    end
    drive(1, 1, 0, 0, 16'h0ABC, 16'h0, 0, 16'h7777);
    chk16("miss_done_data", MEM_mem_data, 16'h1234);
    chk1("miss_done_stall", stall_pipe, 1'b0);
    chk16("miss_done_addr", mem_addr, 16'h0010);
    chk1("miss_done_rd", mem_rd, 1'b0);
    chk16("miss_stalls", 16'(stalls), 16'd3);
    idle();

    // Store with WAIT; store data must be held from the latch.
    drive(1, 0, 1, 0, 16'h0022, 16'hA5A5, 0, 16'h0);
    chk1("st_wr", mem_wr, 1'b1);
    chk1("st_rd", mem_rd, 1'b0);
    chk16("st_wd", mem_wr_data, 16'hA5A5);
    wrs = int'(mem_wr);
    for (int k = 1; k <= 2; k++) begin
      drive(1, 0, 1, 0, 16'h0022, 16'hFFFF, (k == 2), 16'h9999);
      chk16("st_wd_hold", mem_wr_data, 16'hA5A5);
      chk1("st_stall", stall_pipe, 1'b1);
      wrs += int'(mem_wr);
    end
    idle();
    chk16("st_done_data", MEM_mem_data, 16'h0);
    chk1("st_done_stall", stall_pipe, 1'b0);
    chk16("st_strobes", 16'(wrs), 16'd1);

    // Read and write together behaves as a store.
    drive(1, 1, 1, 0, 16'h0030, 16'h1111, 1, 16'h2222);
    chk1("both_wr", mem_wr, 1'b1);
    chk1("both_rd", mem_rd, 1'b0);
    chk16("both_data", MEM_mem_data, 16'h0);

    // Unaligned load, then an aligned load that must be suppressed.
    drive(1, 1, 0, 0, 16'h0013, 16'h0, 1, 16'hBEEF);
    chk1("un_rd", mem_rd, 1'b0);
    chk1("un_err_now", MEM_err, 1'b0);
    chk1("un_stall", stall_pipe, 1'b0);
    drive(1, 1, 0, 0, 16'h0014, 16'h0, 1, 16'hBEEF);
    chk1("un_err", MEM_err, 1'b1);
    chk1("un_after_rd", mem_rd, 1'b0);
    chk16("un_after_data", MEM_mem_data, 16'h0);
    do_reset();
    chk1("un_cleared", MEM_err, 1'b0);

    // Timeout: 15 WAIT cycles with no completion.
    drive(1, 1, 0, 0, 16'h0040, 16'h0, 0, 16'h0);
    stalls = int'(stall_pipe);
    for (int k = 1; k <= MAX_WAIT; k++) begin
      drive(1, 1, 0, 0, 16'h0040, 16'h0, 0, 16'h0);
      chk1("to_err_early", MEM_err, 1'b0);
      stalls += int'(stall_pipe);
    end
    drive(0, 0, 0, 0, 16'h0100, 16'h0, 0, 16'h0);
    chk1("to_err", MEM_err, 1'b1);
    chk1("to_stall", stall_pipe, 1'b0);
    chk16("to_idle_addr", mem_addr, 16'h0100);
    chk16("to_stalls", 16'(stalls), 16'd16);
    do_reset();

    // Halt, then a load that must not be issued.
    drive(1, 0, 0, 1, 16'h0, 16'h0, 0, 16'h0);
    chk1("halt_rd", mem_rd, 1'b0);
    drive(1, 1, 0, 0, 16'h0010, 16'h0, 1, 16'hBEEF);
    chk1("halt_load_rd", mem_rd, 1'b0);
    chk16("halt_load_data", MEM_mem_data, 16'h0);
    do_reset();

    // Reset in the middle of WAIT.
    drive(1, 1, 0, 0, 16'h0050, 16'h0, 0, 16'h0);
    drive(1, 1, 0, 0, 16'h0050, 16'h0, 0, 16'h0);
    chk1("rstw_stall_before", stall_pipe, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk16("rstw_flags", 16'({mem_rd, mem_wr, stall_pipe, wb_bubble, MEM_err}), 16'h0);
    chk16("rstw_addr", mem_addr, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    MEM_valid = 0; MEM_mem_read = 0; mem_done = 1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 16'h0050, 16'h0, 1, 16'h4444);
      chk1("rstw_no_rd", mem_rd, 1'b0);
      chk1("rstw_no_stall", stall_pipe, 1'b0);
    end

    // Randomized episodes.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        int unsigned op;
        @(posedge clk); #1;
        op            = $urandom_range(0, 3);
        rst           = ($urandom_range(0, 199) == 0);
        MEM_valid     = ($urandom_range(0, 99) < 80);
        MEM_mem_read  = op[0];
        MEM_mem_write = op[1];
        MEM_halt      = ($urandom_range(0, 999) < phalt[ep]);
        MEM_EX_out    = 16'($urandom);
        MEM_EX_out[0] = ($urandom_range(0, 99) < punal[ep]);
        MEM_wr_data   = 16'($urandom);
        mem_done      = ($urandom_range(0, 99) < pd[ep]);
        mem_rd_data   = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_stage
